// File: rtl/sample_iterator.sv
// Walks the bounding box of a triangle in raster order and emits one sample per cycle.
// Optional macro SAMPLE_ITERATOR_SCREEN_CLAMP_EN clamps the box to the screen at acceptance.
module sample_iterator #(
  parameter int SIGFIG   = 24,
  parameter int RADIX    = 10,
  parameter int VERTS    = 3,
  parameter int AXIS     = 3,
  parameter int COLORS   = 3,
  parameter int SCREEN_W = 1024 << RADIX,
  parameter int SCREEN_H = 1024 << RADIX
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]      color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]        box_R14S,
  input  logic        [SIGFIG-1:0]                  step_R14U,
  input  logic                                      validTri_R14H,
  output logic                                      halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]      color_R16U,
  output logic signed [1:0][SIGFIG-1:0]             sample_R16S,
  output logic                                      validSamp_R16H
);

  // Sign extension plus a guard bit, so position + full-range step can never wrap.
  localparam int EXT = SIGFIG + 2;

`ifdef SAMPLE_ITERATOR_SCREEN_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  localparam logic        [SIGFIG-1:0] UnitStep = SIGFIG'(1) << RADIX;
  localparam logic signed [EXT-1:0]    MaxX     = EXT'(SCREEN_W - 1);
  localparam logic signed [EXT-1:0]    MaxY     = EXT'(SCREEN_H - 1);

  typedef enum logic {
    IDLE = 1'b0,
    TEST = 1'b1
  } state_t;

  function automatic logic signed [EXT-1:0] extS(input logic signed [SIGFIG-1:0] v);
    return {{2{v[SIGFIG-1]}}, v};
  endfunction

  state_t                                       state_q;
  logic                                         halt_q;
  logic                                         validSamp_q;
  logic signed [1:0][SIGFIG-1:0]                sample_q;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic        [COLORS-1:0][SIGFIG-1:0]         color_q;
  logic        [SIGFIG-1:0]                     llX_q;
  logic signed [EXT-1:0]                        urX_q;
  logic signed [EXT-1:0]                        urY_q;
  logic signed [EXT-1:0]                        step_q;

  logic signed [EXT-1:0] llX_d;
  logic signed [EXT-1:0] llY_d;
  logic signed [EXT-1:0] urX_d;
  logic signed [EXT-1:0] urY_d;
  logic signed [EXT-1:0] step_d;
  logic                  dropTri;
  logic signed [EXT-1:0] sumX;
  logic signed [EXT-1:0] sumY;
  logic                  endOfRow;
  logic                  endOfBox;

  // Box as seen at acceptance, after optional screen clamping, and the raster step arithmetic.
  always_comb begin
    llX_d  = extS(box_R14S[0][0]);
    llY_d  = extS(box_R14S[0][1]);
    urX_d  = extS(box_R14S[1][0]);
    urY_d  = extS(box_R14S[1][1]);
    step_d = {2'b00, (step_R14U == '0) ? UnitStep : step_R14U};
    if (ClampEn) begin
      if (llX_d[EXT-1]) llX_d = '0;
      if (llY_d[EXT-1]) llY_d = '0;
      if (urX_d > MaxX) urX_d = MaxX;
      if (urY_d > MaxY) urY_d = MaxY;
    end
    dropTri  = (llX_d > urX_d) || (llY_d > urY_d);
    sumX     = extS(sample_q[0]) + step_q;
    sumY     = extS(sample_q[1]) + step_q;
    endOfRow = sumX > urX_q;
    endOfBox = endOfRow && (sumY > urY_q);
  end

  // Control and all outputs are registered together so halt and valid track the state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      halt_q      <= 1'b1;
      validSamp_q <= 1'b0;
      sample_q    <= '0;
      tri_q       <= '0;
      color_q     <= '0;
      llX_q       <= '0;
      urX_q       <= '0;
      urY_q       <= '0;
      step_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (validTri_R14H) begin
            tri_q       <= tri_R14S;
            color_q     <= color_R14U;
            llX_q       <= llX_d[SIGFIG-1:0];
            urX_q       <= urX_d;
            urY_q       <= urY_d;
            step_q      <= step_d;
            sample_q[0] <= llX_d[SIGFIG-1:0];
            sample_q[1] <= llY_d[SIGFIG-1:0];
            if (!dropTri) begin
              state_q     <= TEST;
              halt_q      <= 1'b0;
              validSamp_q <= 1'b1;
            end
          end
        end
        TEST: begin
          if (endOfBox) begin
            state_q     <= IDLE;
            halt_q      <= 1'b1;
            validSamp_q <= 1'b0;
          end else if (endOfRow) begin
            sample_q[0] <= llX_q;
            sample_q[1] <= sumY[SIGFIG-1:0];
          end else begin
            sample_q[0] <= sumX[SIGFIG-1:0];
          end
        end
        default: begin
          state_q     <= IDLE;
          halt_q      <= 1'b1;
          validSamp_q <= 1'b0;
        end
      endcase
    end
  end

  assign halt_RnnnnL    = halt_q;
  assign validSamp_R16H = validSamp_q;
  assign sample_R16S    = sample_q;
  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: table of boxes with hand-computed sample counts and
// end points, plus hand sequences for reset mid-triangle and back-to-back triangles.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;

  typedef logic signed [2:0][2:0][SIGFIG-1:0] tri_t;
  typedef logic        [2:0][SIGFIG-1:0]      color_t;

  typedef struct {
    int llx, lly, urx, ury, step;
    int count, firstX, firstY, lastX, lastY;
  } vec_t;

  logic                              clk = 1'b0;
  logic                              rst;
  tri_t                              triIn;
  color_t                            colorIn;
  logic signed [1:0][1:0][SIGFIG-1:0] boxIn;
  logic        [SIGFIG-1:0]          stepIn;
  logic                              validTri;
  logic                              halt;
  tri_t                              triOut;
  color_t                            colorOut;
  logic signed [1:0][SIGFIG-1:0]     sampleOut;
  logic                              validSamp;

  int assertCount = 0;
  int failCount   = 0;

  vec_t vecs[10];

  sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX)) dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R14S       (triIn),
    .color_R14U     (colorIn),
    .box_R14S       (boxIn),
    .step_R14U      (stepIn),
    .validTri_R14H  (validTri),
    .halt_RnnnnL    (halt),
    .tri_R16S       (triOut),
    .color_R16U     (colorOut),
    .sample_R16S    (sampleOut),
    .validSamp_R16H (validSamp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkWide(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic tri_t makeTri(input int idx);
    tri_t t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        t[i][j] = SIGFIG'(idx * 100 + i * 10 + j - 50);
    return t;
  endfunction

  function automatic color_t makeColor(input int idx);
    color_t c;
    for (int k = 0; k < 3; k++) c[k] = SIGFIG'(idx * 7 + k + 1);
    return c;
  endfunction

  function automatic int sampX();
    logic signed [SIGFIG-1:0] v;
    v = sampleOut[0];
    return int'(v);
  endfunction

  function automatic int sampY();
    logic signed [SIGFIG-1:0] v;
    v = sampleOut[1];
    return int'(v);
  endfunction

  task automatic driveTri(input vec_t v, input int idx);
    triIn       = makeTri(idx);
    colorIn     = makeColor(idx);
    boxIn[0][0] = SIGFIG'(v.llx);
    boxIn[0][1] = SIGFIG'(v.lly);
    boxIn[1][0] = SIGFIG'(v.urx);
    boxIn[1][1] = SIGFIG'(v.ury);
    stepIn      = SIGFIG'(v.step);
  endtask

  // Offer one triangle, then follow its samples against a raster walk of the expected box.
  task automatic applyStimulus(input vec_t v, input int idx);
    int    got, lowCycles, ex, ey, stepEff, lastX, lastY;
    string tag;
    tag     = $sformatf("v%0d", idx);
    stepEff = (v.step == 0) ? (1 << RADIX) : v.step;
    driveTri(v, idx);
    validTri = 1'b1;
    checkOutput({tag, "_idle_halt"}, longint'(halt), 1);
    @(negedge clk);
    validTri = 1'b0;
    checkOutput({tag, "_latency"}, longint'(validSamp), (v.count > 0) ? 1 : 0);
    got = 0; lowCycles = 0; lastX = 0; lastY = 0;
    ex = v.firstX; ey = v.firstY;
    for (int c = 0; c < 200; c++) begin
      if (validSamp !== 1'b1) break;
      if (got == 0) begin
        checkOutput({tag, "_first_x"}, sampX(), v.firstX);
        checkOutput({tag, "_first_y"}, sampY(), v.firstY);
      end
      checkOutput($sformatf("%s_s%0d_x", tag, got), sampX(), ex);
      checkOutput($sformatf("%s_s%0d_y", tag, got), sampY(), ey);
      checkWide($sformatf("%s_s%0d_tri", tag, got), triOut, makeTri(idx));
      checkWide($sformatf("%s_s%0d_color", tag, got), colorOut, makeColor(idx));
      if (halt === 1'b0) lowCycles++;
      lastX = sampX(); lastY = sampY();
      got++;
      ex += stepEff;
      if (ex > v.urx) begin
        ex = v.firstX;
        ey += stepEff;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_count"}, got, v.count);
    checkOutput({tag, "_halt_low_cycles"}, lowCycles, v.count);
    checkOutput({tag, "_end_halt"}, longint'(halt), 1);
    checkOutput({tag, "_end_valid"}, longint'(validSamp), 0);
    if (v.count > 0) begin
      checkOutput({tag, "_last_x"}, lastX, v.lastX);
      checkOutput({tag, "_last_y"}, lastY, v.lastY);
    end
  endtask

  int   expV[6];
  int   expH[6];
  int   expX[6];
  int   expY[6];
  int   expT[6];
  vec_t vecA, vecB;

  initial begin
    vecs[0] = '{0, 0, 2048, 1024, 1024,    6, 0, 0, 2048, 1024};
    vecs[1] = '{512, 512, 512, 512, 0,     1, 512, 512, 512, 512};
    vecs[2] = '{3000, 0, 2000, 0, 1024,    0, 0, 0, 0, 0};
    vecs[4] = '{100, 200, 1100, 1300, 500, 9, 100, 200, 1100, 1200};
    vecs[5] = '{0, 0, 0, 1024, 0,          2, 0, 0, 0, 1024};
    vecs[6] = '{0, 10, 5, 0, 1024,         0, 0, 0, 0, 0};
`ifdef SAMPLE_ITERATOR_SCREEN_CLAMP_EN
    vecs[3] = '{-2048, 0, 1024, 0, 1024,   2, 0, 0, 1024, 0};
    vecs[7] = '{8388607, 0, 8388607, 0, 16777215, 0, 0, 0, 0, 0};
    vecs[8] = '{8388000, 0, 8388607, 0, 1000,     0, 0, 0, 0, 0};
    vecs[9] = '{0, -3000, 0, 0, 1024,      1, 0, 0, 0, 0};
`else
    vecs[3] = '{-2048, 0, 1024, 0, 1024,   4, -2048, 0, 1024, 0};
    vecs[7] = '{8388607, 0, 8388607, 0, 16777215, 1, 8388607, 0, 8388607, 0};
    vecs[8] = '{8388000, 0, 8388607, 0, 1000,     1, 8388000, 0, 8388000, 0};
    vecs[9] = '{0, -3000, 0, 0, 1024,      3, 0, -3000, 0, -952};
`endif

    rst      = 1'b0;
    validTri = 1'b0;
    triIn    = '0;
    colorIn  = '0;
    boxIn    = '0;
    stepIn   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_halt", longint'(halt), 1);
    checkOutput("reset_valid", longint'(validSamp), 0);
    checkOutput("reset_x", sampX(), 0);
    checkOutput("reset_y", sampY(), 0);
    checkWide("reset_tri", triOut, '0);
    checkWide("reset_color", colorOut, '0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    $display("[TB] reset during third sample");
    driveTri(vecs[0], 20);
    validTri = 1'b1;
    @(negedge clk);
    validTri = 1'b0;
    checkOutput("mid_s0_x", sampX(), 0);
    @(negedge clk);
    checkOutput("mid_s1_x", sampX(), 1024);
    @(negedge clk);
    checkOutput("mid_s2_x", sampX(), 2048);
    checkOutput("mid_s2_valid", longint'(validSamp), 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", longint'(validSamp), 0);
    checkOutput("mid_rst_halt", longint'(halt), 1);
    checkOutput("mid_rst_x", sampX(), 0);
    checkOutput("mid_rst_y", sampY(), 0);
    checkWide("mid_rst_tri", triOut, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_quiet%0d", k), longint'(validSamp), 0);
    end
    applyStimulus(vecs[4], 21);

    $display("[TB] back-to-back triangles with validTri held");
    vecA = '{0, 0, 1024, 0, 1024,       2, 0, 0, 1024, 0};
    vecB = '{5000, 3000, 5000, 4024, 1024, 2, 5000, 3000, 5000, 4024};
    expV = '{1, 1, 0, 1, 1, 0};
    expH = '{0, 0, 1, 0, 0, 1};
    expX = '{0, 1024, 0, 5000, 5000, 0};
    expY = '{0, 0, 0, 3000, 4024, 0};
    expT = '{30, 30, 0, 31, 31, 0};
    driveTri(vecA, 30);
    validTri = 1'b1;
    checkOutput("b2b_idle_halt", longint'(halt), 1);
    @(negedge clk);
    driveTri(vecB, 31);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) validTri = 1'b0;
      checkOutput($sformatf("b2b_c%0d_valid", k), longint'(validSamp), expV[k]);
      checkOutput($sformatf("b2b_c%0d_halt", k), longint'(halt), expH[k]);
      if (expV[k] == 1) begin
        checkOutput($sformatf("b2b_c%0d_x", k), sampX(), expX[k]);
        checkOutput($sformatf("b2b_c%0d_y", k), sampY(), expY[k]);
        checkWide($sformatf("b2b_c%0d_tri", k), triOut, makeTri(expT[k]));
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
